id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Issue controller between the IF/ID register and the decoder's ID/EX register.
//  - Decides each cycle whether the decoded instruction issues, stalls or is killed.
//  - Keeps a load-use scoreboard of in-flight load destinations.
//  - Applies EX-stage redirects (branch/jump) as a flush of the younger stages.
//  - Drives the stall/flush/valid controls the decoder and fetch stage consume.
// PARAMETERS
//  NREG      32  architectural registers tracked (x0 never tracked)
//  LD_LAT    2   cycles from load issue to earliest forwardable result
//  CNT_W     16  width of optional statistics counters
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  id_valid       in   1   IF/ID holds a valid instruction
//  id_rs1         in   5   source 1 of the ID instruction
//  id_rs2         in   5   source 2 of the ID instruction
//  id_uses_rs1    in   1   instruction reads rs1
//  id_uses_rs2    in   1   instruction reads rs2
//  id_rd          in   5   destination of the ID instruction
//  id_is_load     in   1   instruction is LB/LH/LW/LBU/LHU
//  ex_redirect    in   1   EX resolved taken branch/jump, flush younger stages
//  ld_done        in   1   load result available for forwarding this cycle
//  ld_done_rd     in   5   destination register of that load
//  issue          out  1   ID instruction is written into ID/EX this cycle
//  stall_if       out  1   hold PC and IF/ID register
//  flush_id       out  1   clear IF/ID valid
//  bubble_ex      out  1   write a NOP (valid=0) into ID/EX
//  sb_busy        out  NREG  scoreboard bit vector (debug/verification)
// BEHAVIOUR
//  - Reset: all outputs 0, sb_busy = 0, FSM = RUN, load timers cleared.
//  - Hazard: hz = id_valid & ((id_uses_rs1 & sb_busy[id_rs1] & rs1!=0) | same for rs2).
//  - FSM RUN:
//    - ex_redirect -> FLUSH: flush_id=1, bubble_ex=1, issue=0.
//    - else hz -> STALL: stall_if=1, bubble_ex=1, issue=0.
//    - else issue = id_valid; bubble_ex = ~id_valid.
//  - FSM STALL:
//    - stall_if=1, bubble_ex=1 while hz remains true.
//    - -> RUN the cycle hz drops; issue in that same cycle (0-cycle exit).
//    - ex_redirect overrides -> FLUSH.
//  - FSM FLUSH: exactly one cycle. issue=0, bubble_ex=1, then -> RUN.
//  - Redirect priority: ex_redirect in any state wins over hz and stall.
//  - Scoreboard set/clear:
//    - Set: on issue & id_is_load & id_rd!=0, sb_busy[id_rd] <= 1.
//    - Clear: ld_done clears sb_busy[ld_done_rd].
//    - Set and clear of the same rd in one cycle: set wins (newer load).
//    - Redirect does not clear the scoreboard; loads already in EX are older and still complete.
//  - Combinational timing and latency:
//    - Outputs are combinational from FSM state and inputs; no registered delay on stall.
//    - Issue-to-issue latency with no hazard: 1 instruction per cycle.
//  - Reset asserted mid-stall: next cycle FSM = RUN, scoreboard cleared, no issue.
// CONFIGURATION
//  HAZARD_STATS_EN:
//   - Defined: adds registered CNT_W-bit outputs stall_cycles, flush_count and issue_count.
//     - All three reset to 0 and saturate at all-ones; no wrap.
//   - Undefined: the counter ports and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared package PipelineReg gains:
//    - typedef enum logic [1:0] {RUN, STALL, FLUSH} issue_state_t.
//    - localparam REG_ZERO = 5'd0.
//  - Sub-module ld_scoreboard: owns sb_busy and the set/clear/priority rules.
//  - id_issue_ctrl: instantiates ld_scoreboard and implements the FSM and outputs.
// TESTING
//  - Independent stream: 4 valid ADDs, no loads -> issue=1 each cycle, stall_if=0 throughout.
//  - Load-use:
//    - Stimulus: LW x5 issues, next instruction ADD x6,x5,x1 (uses_rs1), ld_done x5 two cycles later.
//    - Response: 2 cycles with stall_if=1 and bubble_ex=1, then issue=1.
//  - x0 load: LW x0 then ADD reading x0 -> no stall, sb_busy stays 0.
//  - Redirect during stall: ex_redirect=1 in STALL -> flush_id=1, bubble_ex=1 for 1 cycle, then RUN.
//  - Same-cycle set and clear: ld_done x7 plus issue of LW x7 -> sb_busy[7] remains 1.
//  - Reset mid-stall: reset=1 while STALL with sb_busy[5]=1.
//    - Next cycle: all outputs 0, sb_busy=0.
//    - With HAZARD_STATS_EN defined: counters also read 0.

Source files
------------

// File: rtl/id_issue_ctrl_pkg.sv
// Shared types for the ID issue controller and its load-use scoreboard.
// Holds the issue FSM encoding and the hard-wired zero register index.
package id_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } issue_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic src_hazard(
    input logic       uses,
    input logic [4:0] rs,
    input logic       busy
  );
    return uses & busy & (rs != REG_ZERO);
  endfunction

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Decode-side bundle between IF/ID, ID/EX and the issue controller.
// master drives the instruction/EX/load inputs, slave returns the controls.
interface id_issue_ctrl_if #(
  parameter int NREG = 32
);

  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic [4:0]      id_rd;
  logic            id_is_load;
  logic            ex_redirect;
  logic            ld_done;
  logic [4:0]      ld_done_rd;
  logic            issue;
  logic            stall_if;
  logic            flush_id;
  logic            bubble_ex;
  logic [NREG-1:0] sb_busy;

  modport master (
    output id_valid,
    output id_rs1,
    output id_rs2,
    output id_uses_rs1,
    output id_uses_rs2,
    output id_rd,
    output id_is_load,
    output ex_redirect,
    output ld_done,
    output ld_done_rd,
    input  issue,
    input  stall_if,
    input  flush_id,
    input  bubble_ex,
    input  sb_busy
  );

  modport slave (
    input  id_valid,
    input  id_rs1,
    input  id_rs2,
    input  id_uses_rs1,
    input  id_uses_rs2,
    input  id_rd,
    input  id_is_load,
    input  ex_redirect,
    input  ld_done,
    input  ld_done_rd,
    output issue,
    output stall_if,
    output flush_id,
    output bubble_ex,
    output sb_busy
  );

endinterface

// File: rtl/id_issue_ctrl_ld_scoreboard.sv
// In-flight load destination scoreboard; a new load wins over a same-cycle
// completion of the same register, and x0 is never marked busy.
module ld_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int LD_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [4:0]      set_rd,
  input  logic            clr_en,
  input  logic [4:0]      clr_rd,
  output logic [NREG-1:0] busy
);

  // ld_done can never coincide with the issue of its own load
  if (LD_LAT < 1) begin : g_lat_chk
    $error("ld_scoreboard: LD_LAT must be >= 1");
  end

  logic [NREG-1:0] busy_d;

  always_comb begin
    busy_d = busy;
    if (clr_en) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (set_en && (set_rd != REG_ZERO)) begin
      busy_d[set_rd] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_d;
    end
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID issue controller: load-use stall, EX redirect flush, issue control.
// Optional saturating statistics counters behind HAZARD_STATS_EN.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int LD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_issue_ctrl_if.slave   bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] issue_count
`endif
);

  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_STALL = 2'(STALL);
  localparam logic [1:0] ST_FLUSH = 2'(FLUSH);

  if (CNT_W < 1) begin : g_cnt_chk
    $error("id_issue_ctrl: CNT_W must be >= 1");
  end

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [NREG-1:0] sb_busy;
  logic            hz;
  logic            issue;
  logic            stall_if;
  logic            flush_id;
  logic            bubble_ex;

  ld_scoreboard #(
    .NREG   (NREG),
    .LD_LAT (LD_LAT)
  ) u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (issue & bus.id_is_load),
    .set_rd (bus.id_rd),
    .clr_en (bus.ld_done),
    .clr_rd (bus.ld_done_rd),
    .busy   (sb_busy)
  );

  assign hz = bus.id_valid & (
    src_hazard(bus.id_uses_rs1, bus.id_rs1,
               sb_busy[bus.id_rs1]) |
    src_hazard(bus.id_uses_rs2, bus.id_rs2,
               sb_busy[bus.id_rs2]));

  // STALL exits to RUN in the same cycle hz drops
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    stall_if  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    priority case (1'b1)
      reset: begin
        state_d = ST_RUN;
      end
      bus.ex_redirect: begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = ST_FLUSH;
      end
      (state_q == ST_FLUSH): begin
        bubble_ex = 1'b1;
        state_d   = ST_RUN;
      end
      hz: begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
        state_d   = ST_STALL;
      end
      default: begin
        issue     = bus.id_valid;
        bubble_ex = ~bus.id_valid;
        state_d   = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.issue     = issue;
  assign bus.stall_if  = stall_if;
  assign bus.flush_id  = flush_id;
  assign bus.bubble_ex = bubble_ex;
  assign bus.sb_busy   = sb_busy;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      issue_count  <= '0;
    end else begin
      if (stall_if && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush_id && (flush_count != '1)) begin
        flush_count <= flush_count + 1'b1;
      end
      if (issue && (issue_count != '1)) begin
        issue_count <= issue_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl; ctl = {issue,stall_if,flush_id,bubble_ex}.
// Define HAZARD_STATS_EN to also cover the statistics counters.
module tb_id_issue_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  id_issue_ctrl_if #(.NREG(32)) bus ();

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
  logic [15:0] issue_count;
`endif

  id_issue_ctrl #(
    .NREG   (32),
    .LD_LAT (2),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .issue_count  (issue_count)
`endif
  );

  logic [3:0] ctl;
  assign ctl = {bus.issue, bus.stall_if,
                bus.flush_id, bus.bubble_ex};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(
    input logic       v,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       u1,
    input logic       u2,
    input logic [4:0] rd,
    input logic       ld,
    input logic       redir,
    input logic       ldd,
    input logic [4:0] ldd_rd
  );
    bus.id_valid    = v;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
    bus.id_rd       = rd;
    bus.id_is_load  = ld;
    bus.ex_redirect = redir;
    bus.ld_done     = ldd;
    bus.ld_done_rd  = ldd_rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    @(negedge clk); #1;
    n_chk++;
    if (ctl !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 0000", ctl);
    end
    n_chk++;
    if (bus.sb_busy !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_sb: got %h want 0", bus.sb_busy);
    end
`ifdef HAZARD_STATS_EN
    n_chk++;
    if ({stall_cycles, flush_count, issue_count} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %h/%h/%h want 0",
               stall_cycles, flush_count, issue_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if (ctl !== 4'b0001) begin
      n_fail++;
      $display("FAIL idle_ctl: got %b want 0001", ctl);
    end
  endtask

  task automatic test_independent();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 5'(i + 1), 5'(i + 2), 1, 1, 5'(i + 10), 0, 0, 0, 0);
      #1;
      n_chk++;
      if (ctl !== 4'b1000) begin
        n_fail++;
        $display("FAIL indep_%0d: got %b want 1000", i, ctl);
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 5, 1, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL lu_lw: got %b want 1000", ctl);
    end
    @(negedge clk);
    drive(1, 5, 1, 1, 0, 6, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b0101) begin
      n_fail++;
      $display("FAIL lu_stall1: got %b want 0101", ctl);
    end
    n_chk++;
    if (bus.sb_busy !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL lu_sb: got %h want 20", bus.sb_busy);
    end
    @(negedge clk);
    drive(1, 5, 1, 1, 0, 6, 0, 0, 1, 5);
    #1;
    n_chk++;
    if (ctl !== 4'b0101) begin
      n_fail++;
      $display("FAIL lu_stall2: got %b want 0101", ctl);
    end
    @(negedge clk);
    drive(1, 5, 1, 1, 0, 6, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL lu_issue: got %b want 1000", ctl);
    end
    n_chk++;
    if (bus.sb_busy !== 32'h0) begin
      n_fail++;
      $display("FAIL lu_sb_clr: got %h want 0", bus.sb_busy);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_x0_load();
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL x0_lw: got %b want 1000", ctl);
    end
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 6, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL x0_add: got %b want 1000", ctl);
    end
    n_chk++;
    if (bus.sb_busy !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_sb: got %h want 0", bus.sb_busy);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_redirect_stall();
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 5, 0, 1, 0, 6, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b0101) begin
      n_fail++;
      $display("FAIL rd_stall: got %b want 0101", ctl);
    end
    @(negedge clk);
    drive(1, 5, 0, 1, 0, 6, 0, 1, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b0011) begin
      n_fail++;
      $display("FAIL rd_flush: got %b want 0011", ctl);
    end
    @(negedge clk);
    drive(1, 1, 2, 1, 1, 6, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b0001) begin
      n_fail++;
      $display("FAIL rd_flush_st: got %b want 0001", ctl);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL rd_run: got %b want 1000", ctl);
    end
    n_chk++;
    if (bus.sb_busy !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL rd_sb_kept: got %h want 20", bus.sb_busy);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    @(negedge clk);
    idle();
    #1;
    n_chk++;
    if (bus.sb_busy !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_sb_clr: got %h want 0", bus.sb_busy);
    end
  endtask

  task automatic test_redirect_run();
    @(negedge clk);
    drive(1, 1, 2, 1, 1, 8, 0, 1, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b0011) begin
      n_fail++;
      $display("FAIL rr_flush: got %b want 0011", ctl);
    end
    @(negedge clk);
    drive(1, 1, 2, 1, 1, 8, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_flush_st: got %b want 0001", ctl);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL rr_run: got %b want 1000", ctl);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_set_clear();
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 7, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 7, 1, 0, 1, 7);
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL sc_issue: got %b want 1000", ctl);
    end
    @(negedge clk);
    idle();
    #1;
    n_chk++;
    if (bus.sb_busy !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL sc_sb: got %h want 80", bus.sb_busy);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7);
    @(negedge clk);
    idle();
    #1;
    n_chk++;
    if (bus.sb_busy !== 32'h0) begin
      n_fail++;
      $display("FAIL sc_sb_clr: got %h want 0", bus.sb_busy);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    drive(1, 1, 0, 1, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    drive(1, 5, 0, 1, 0, 6, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (ctl !== 4'b0101) begin
      n_fail++;
      $display("FAIL rs_stall: got %b want 0101", ctl);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (ctl !== 4'b0000) begin
      n_fail++;
      $display("FAIL rs_ctl: got %b want 0000", ctl);
    end
    n_chk++;
    if (bus.sb_busy !== 32'h0) begin
      n_fail++;
      $display("FAIL rs_sb: got %h want 0", bus.sb_busy);
    end
`ifdef HAZARD_STATS_EN
    n_chk++;
    if ({stall_cycles, flush_count, issue_count} !== 48'h0) begin
      n_fail++;
      $display("FAIL rs_cnt: got %h/%h/%h want 0",
               stall_cycles, flush_count, issue_count);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if (ctl !== 4'b1000) begin
      n_fail++;
      $display("FAIL rs_run: got %b want 1000", ctl);
    end
    @(negedge clk);
    idle();
`ifdef HAZARD_STATS_EN
    #1;
    n_chk++;
    if (issue_count !== 16'd1) begin
      n_fail++;
      $display("FAIL rs_icnt: got %0d want 1", issue_count);
    end
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_independent();
    test_load_use();
    test_x0_load();
    test_redirect_stall();
    test_redirect_run();
    test_set_clear();
    test_reset_mid_stall();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
